noc_flit_packetizer: RTL



---
 rtl/noc_flit_packetizer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/noc_flit_packetizer.sv
// Local-side NoC packet injector: turns a descriptor plus a payload word stream
// into head/body/tail flits on a per-VC valid/ready sender port.
module noc_flit_packetizer #(
    parameter int unsigned CHANNELS   = 2,
    parameter int unsigned FLIT_WIDTH = 32,
    parameter int unsigned DEST_WIDTH = 8,
    parameter int unsigned MAX_LEN    = 16,
    localparam int unsigned VC_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1),
    localparam int unsigned PW    = FLIT_WIDTH - 2
) (
    input  logic                  noc_clk,
    input  logic                  noc_rst_n,
    input  logic                  i_clear,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [VC_W-1:0]       i_req_vc,
    input  logic [DEST_WIDTH-1:0] i_req_dest,
    input  logic [LEN_W-1:0]      i_req_len,
    input  logic                  i_pld_valid,
    output logic                  o_pld_ready,
    input  logic [PW-1:0]         i_pld_data,
    output logic                  o_busy,
    output logic [CHANNELS-1:0]   sender_valid,
    output logic [FLIT_WIDTH-1:0] sender_flit,
    input  logic [CHANNELS-1:0]   sender_ready,
    input  logic [CHANNELS-1:0]   sender_vc_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEAD = 2'd1,
        BODY = 2'd2
    } state_t;

    state_t                  state;
    logic                    ov;
    logic [FLIT_WIDTH-1:0]   oflit;
    logic [VC_W-1:0]         ovc;
    logic [VC_W-1:0]         vc;
    logic [DEST_WIDTH-1:0]   dest;
    logic [LEN_W-1:0]        len;
    logic [LEN_W-1:0]        remaining;

    logic                    accept;
    logic                    slot_free;
    logic                    last_word;
    logic [VC_W-1:0]         req_vc_m;
    logic [LEN_W-1:0]        req_len_c;
    logic [FLIT_WIDTH-1:0]   head_flit;
    logic [FLIT_WIDTH-1:0]   pld_flit;

    // Output slot can take a new flit when empty or being drained this cycle
    assign accept    = ov & sender_ready[ovc];
    assign slot_free = ~ov | accept;
    assign last_word = (remaining == LEN_W'(1));

    assign req_vc_m  = VC_W'(32'(i_req_vc) % CHANNELS);
    assign req_len_c = (32'(i_req_len) > MAX_LEN) ? LEN_W'(MAX_LEN) : i_req_len;

    always_comb begin
        head_flit                        = '0;
        head_flit[DEST_WIDTH-1:0]        = dest;
        head_flit[DEST_WIDTH +: LEN_W]   = len;
        head_flit[FLIT_WIDTH-1 -: 2]     = (len == '0) ? 2'b11 : 2'b01;
    end

    assign pld_flit = {(last_word ? 2'b10 : 2'b00), i_pld_data};

    assign sender_valid = ov ? (CHANNELS'(1) << ovc) : '0;
    assign sender_flit  = oflit;
    assign o_req_ready  = (state == IDLE);
    assign o_pld_ready  = (state == BODY) & slot_free;
    assign o_busy       = (state != IDLE) | ov;

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            state     <= IDLE;
            ov        <= 1'b0;
            oflit     <= '0;
            ovc       <= '0;
            vc        <= '0;
            dest      <= '0;
            len       <= '0;
            remaining <= '0;
        end else if (i_clear) begin
            state     <= IDLE;
            ov        <= 1'b0;
            oflit     <= '0;
            remaining <= '0;
        end else begin
            if (accept) begin
                ov <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (i_req_valid) begin
                        vc        <= req_vc_m;
                        dest      <= i_req_dest;
                        len       <= req_len_c;
                        remaining <= req_len_c;
                        state     <= HEAD;
                    end
                end
                // vc_ready (FIFO almost-full) only gates the start of a packet
                HEAD: begin
                    if (slot_free && sender_vc_ready[vc]) begin
                        ov    <= 1'b1;
                        ovc   <= vc;
                        oflit <= head_flit;
                        state <= (len == '0) ? IDLE : BODY;
                    end
                end
                BODY: begin
                    if (i_pld_valid && slot_free) begin
                        ov        <= 1'b1;
                        ovc       <= vc;
                        oflit     <= pld_flit;
                        remaining <= remaining - LEN_W'(1);
                        if (last_word) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
